// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter giving N clients read/write access to one sync RAM.
// One transaction at a time: grant, issue, optional read wait, done pulse.
module mem_arbiter_rr #(
  parameter int N_CLIENTS = 3,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          req,
  input  logic [N_CLIENTS-1:0]          wr,
  input  logic [N_CLIENTS*AW-1:0]       addr,
  input  logic [N_CLIENTS*DW-1:0]       wdata,
  output logic [DW-1:0]                 rdata,
  output logic [N_CLIENTS-1:0]          done,
  output logic [$clog2(N_CLIENTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  output logic                          mem_wren,
  input  logic [DW-1:0]                 mem_q
);

  localparam int IW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_ptr;
  logic [CW-1:0]   wait_cnt;
  logic            wr_lat;

  logic            hi_found;
  logic [IW-1:0]   hi_pick;
  logic [IW-1:0]   lo_pick;
  logic [IW-1:0]   pick;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [N_CLIENTS-1:0] grant_oh;

  // Lowest requester above last_ptr wins; otherwise wrap to the lowest one.
  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IW'(i) > last_ptr) begin
          hi_found = 1'b1;
          hi_pick  = IW'(i);
        end else begin
          lo_pick  = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (IW'(i) == pick) begin
        sel_wr    = wr[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      grant_oh[i] = (IW'(i) == grant_id);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ptr  <= IW'(N_CLIENTS - 1);
      wait_cnt  <= '0;
      wr_lat    <= 1'b0;
      grant_id  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      rdata     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_id  <= pick;
            wr_lat    <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wren  <= sel_wr;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wren <= 1'b0;
          wait_cnt <= '0;
          if (wr_lat) begin
            done  <= grant_oh;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CW'(RD_LAT - 1)) begin
            rdata <= mem_q;
            done  <= grant_oh;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          last_ptr <= grant_id;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: transaction-level model for a 3-client instance,
// directed latency and sweep checks for a 4-client, RD_LAT=1 instance.
module tb_mem_arbiter_rr;

  localparam int NA  = 3;
  localparam int RLA = 2;
  localparam int NB  = 4;
  localparam int RLB = 1;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } op_t;

  typedef struct {
    int         cl;
    int         lat;
    logic [7:0] rd;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic             a_reset;
  logic [NA-1:0]    a_req, a_wr, a_done;
  logic [NA*8-1:0]  a_addr, a_wdata;
  logic [7:0]       a_rdata, a_maddr, a_mwdata, a_mq;
  logic [1:0]       a_gid;
  logic             a_busy, a_mwren;

  mem_arbiter_rr #(.N_CLIENTS(NA), .AW(8), .DW(8), .RD_LAT(RLA)) dut_a (
    .clk(clk), .reset(a_reset), .req(a_req), .wr(a_wr),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .done(a_done),
    .grant_id(a_gid), .busy(a_busy), .mem_addr(a_maddr),
    .mem_wdata(a_mwdata), .mem_wren(a_mwren), .mem_q(a_mq)
  );

  // Instance B
  logic             b_reset;
  logic [NB-1:0]    b_req, b_wr, b_done;
  logic [NB*8-1:0]  b_addr, b_wdata;
  logic [7:0]       b_rdata, b_maddr, b_mwdata, b_mq;
  logic [1:0]       b_gid;
  logic             b_busy, b_mwren;

  mem_arbiter_rr #(.N_CLIENTS(NB), .AW(8), .DW(8), .RD_LAT(RLB)) dut_b (
    .clk(clk), .reset(b_reset), .req(b_req), .wr(b_wr),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .done(b_done),
    .grant_id(b_gid), .busy(b_busy), .mem_addr(b_maddr),
    .mem_wdata(b_mwdata), .mem_wren(b_mwren), .mem_q(b_mq)
  );

  // RAMs with RD_LAT register stages on the read path
  logic [7:0] ram_a [256];
  logic [7:0] qa [RLA];
  always @(posedge clk) begin
    if (a_mwren) ram_a[a_maddr] <= a_mwdata;
    qa[0] <= ram_a[a_maddr];
    qa[1] <= qa[0];
  end
  assign a_mq = qa[RLA-1];

  logic [7:0] ram_b [256];
  logic [7:0] qb;
  always @(posedge clk) begin
    if (b_mwren) ram_b[b_maddr] <= b_mwdata;
    qb <= ram_b[b_maddr];
  end
  assign b_mq = qb;

  // Transaction-level model of instance A
  int         cyc = 0;
  bit         mvalid = 0;
  bit         active = 0;
  int         t_g, t_done, gid, ptr, mj;
  bit         mwr;
  logic [7:0] maddr, mwdata, rdata_m, rd_pend;
  logic [7:0] mmem [256];

  always @(posedge clk) begin
    if (a_reset) begin
      mvalid = 1; active = 0; ptr = NA - 1; gid = 0; mwr = 0;
      maddr = 0; mwdata = 0; rdata_m = 0;
    end else if (active) begin
      if (!mwr && cyc == t_done - 1) rdata_m = rd_pend;
      if (cyc == t_done) begin
        active = 0;
        ptr = gid;
      end
    end else if (|a_req) begin
      for (int k = 1; k <= NA; k++) begin
        mj = (ptr + k) % NA;
        if (!active && a_req[mj]) begin
          active = 1;
          gid    = mj;
          mwr    = a_wr[mj];
          maddr  = a_addr[mj*8 +: 8];
          mwdata = a_wdata[mj*8 +: 8];
          t_g    = cyc;
          t_done = cyc + 2 + (mwr ? 0 : RLA);
          if (mwr) mmem[maddr] = mwdata;
          else     rd_pend = mmem[maddr];
        end
      end
    end
    cyc++;
  end

  // Driver state and event log
  op_t        opq [NA][$];
  int         load_cyc [NA];
  logic [NA-1:0] last_done = '0;
  evt_t       evq [$];
  int         wren_cnt = 0;
  logic [7:0] wren_a, wren_d;

  logic [30:0] exp_v, act_v;
  int          dcl;

  always @(negedge clk) begin
    last_done = a_done;
    if (mvalid) begin
      exp_v = {active,
               (active && cyc == t_done) ? 3'(1 << gid) : 3'b000,
               active && mwr && cyc == t_g + 1,
               2'(gid), maddr, mwdata, rdata_m};
      act_v = {a_busy, a_done, a_mwren, a_gid, a_maddr, a_mwdata, a_rdata};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cyc%0d actual=%h required=%h", cyc, act_v, exp_v);
      end
    end
    dcl = -1;
    for (int i = 0; i < NA; i++) if (a_done[i]) dcl = i;
    if (dcl >= 0) evq.push_back('{dcl, cyc - load_cyc[dcl], a_rdata});
    if (a_mwren) begin
      wren_cnt++;
      wren_a = a_maddr;
      wren_d = a_mwdata;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NA; i++) if (opq[i].size() > 0) return 1'b1;
    return |a_req;
  endfunction

  task automatic tick();
    op_t o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NA; i++) begin
      if (a_req[i] && last_done[i]) a_req[i] = 1'b0;
      if (!a_req[i] && opq[i].size() > 0) begin
        o = opq[i].pop_front();
        a_wr[i] = o.w;
        a_addr[i*8 +: 8] = o.a;
        a_wdata[i*8 +: 8] = o.d;
        a_req[i] = 1'b1;
        load_cyc[i] = cyc;
      end
    end
  endtask

  task automatic run_a(input int limit);
    int n;
    n = 0;
    tick();
    while (pending() && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      errors++;
      $display("FAIL run_a_timeout actual=%0d required=<%0d", n, limit);
    end
    tick();
    tick();
  endtask

  task automatic b_txn(input int c, input bit w, input logic [7:0] a,
                       input logic [7:0] d, output int lat,
                       output logic [7:0] rd);
    int k;
    bit got;
    got = 0;
    rd = 0;
    b_req = '0;
    b_wr[c] = w;
    b_addr[c*8 +: 8] = a;
    b_wdata[c*8 +: 8] = d;
    b_req[c] = 1'b1;
    for (k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (b_done[c]) begin
        got = 1;
        rd = b_rdata;
      end
    end
    lat = got ? k - 1 : -1;
    if (!got) begin
      errors++;
      $display("FAIL b_timeout client=%0d actual=none required=done", c);
    end
    @(posedge clk);
    #1;
    b_req = '0;
  endtask

  int         exp3 [6] = '{0, 1, 2, 0, 1, 2};
  int         exp4 [6] = '{2, 0, 2, 1, 2, 0};
  int         lat;
  logic [7:0] rd, ed;

  initial begin
    a_reset = 1; a_req = '0; a_wr = '0; a_addr = '0; a_wdata = '0;
    b_reset = 1; b_req = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
    tick();
    tick();
    chk("reset_state", int'({a_busy, a_done, a_mwren, a_gid, a_maddr,
                             a_mwdata, a_rdata}), 0);
    a_reset = 0;

    // 1: client0 write
    evq.delete();
    wren_cnt = 0;
    opq[0].push_back('{1'b1, 8'h10, 8'hA5});
    run_a(50);
    chk("t1_events", evq.size(), 1);
    if (evq.size() > 0) begin
      chk("t1_client", evq[0].cl, 0);
      chk("t1_latency", evq[0].lat, 2);
    end
    chk("t1_wren_cycles", wren_cnt, 1);
    chk("t1_wren_addr", int'(wren_a), 'h10);
    chk("t1_wren_data", int'(wren_d), 'hA5);

    // 2: client1 read back
    evq.delete();
    opq[1].push_back('{1'b0, 8'h10, 8'h00});
    run_a(50);
    chk("t2_events", evq.size(), 1);
    if (evq.size() > 0) begin
      chk("t2_client", evq[0].cl, 1);
      chk("t2_latency", evq[0].lat, 4);
      chk("t2_rdata", int'(evq[0].rd), 'hA5);
    end

    // 3: all clients requesting from reset
    a_reset = 1;
    for (int i = 0; i < NA; i++)
      for (int k = 0; k < 2; k++)
        opq[i].push_back('{1'b1, 8'(8'h20 + i*2 + k), 8'(8'h60 + i*2 + k)});
    tick();
    tick();
    evq.delete();
    a_reset = 0;
    run_a(100);
    chk("t3_events", evq.size(), 6);
    for (int i = 0; i < evq.size() && i < 6; i++)
      chk($sformatf("t3_order%0d", i), evq[i].cl, exp3[i]);

    // 4: round-robin pointer
    evq.delete();
    opq[2].push_back('{1'b1, 8'h30, 8'h11});
    run_a(50);
    opq[0].push_back('{1'b1, 8'h31, 8'h22});
    opq[2].push_back('{1'b1, 8'h32, 8'h33});
    run_a(50);
    opq[1].push_back('{1'b1, 8'h33, 8'h44});
    run_a(50);
    opq[0].push_back('{1'b1, 8'h34, 8'h55});
    opq[2].push_back('{1'b1, 8'h35, 8'h66});
    run_a(50);
    chk("t4_events", evq.size(), 6);
    for (int i = 0; i < evq.size() && i < 6; i++)
      chk($sformatf("t4_order%0d", i), evq[i].cl, exp4[i]);

    // 5: reset during read wait
    evq.delete();
    opq[1].push_back('{1'b0, 8'h10, 8'h00});
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t5_busy_in_wait", int'(a_busy), 1);
    a_reset = 1;
    a_req = '0;
    tick();
    chk("t5_after_reset", int'({a_busy, a_done, a_mwren, a_gid, a_maddr,
                                a_mwdata, a_rdata}), 0);
    a_reset = 0;
    opq[2].push_back('{1'b1, 8'h40, 8'h5C});
    run_a(50);
    chk("t5_events", evq.size(), 1);
    if (evq.size() > 0) begin
      chk("t5_client", evq[0].cl, 2);
      chk("t5_latency", evq[0].lat, 2);
    end

    // 6: four clients, RD_LAT=1
    @(posedge clk);
    #1;
    b_reset = 0;
    b_txn(3, 1'b1, 8'h00, 8'h77, lat, rd);
    chk("t6_write_latency", lat, 2);
    b_txn(3, 1'b0, 8'h00, 8'h00, lat, rd);
    chk("t6_read_latency", lat, 3);
    chk("t6_read_data", int'(rd), 'h77);
    for (int i = 0; i < 256; i++) begin
      ed = 8'((i * 37 + 11) ^ 8'h5A);
      b_txn(i % NB, 1'b1, 8'(i), ed, lat, rd);
    end
    for (int i = 0; i < 256; i++) begin
      ed = 8'((i * 37 + 11) ^ 8'h5A);
      b_txn((i + 1) % NB, 1'b0, 8'(i), 8'h00, lat, rd);
      chk($sformatf("t6_sweep%0d", i), int'(rd), int'(ed));
      if (lat != 3) chk($sformatf("t6_sweep_lat%0d", i), lat, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
